// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and defaults for the traffic request conditioner
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVING = 2'd2
  } channel_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_WAIT_WIDTH      = 8;

endpackage

// File: rtl/traffic_request_conditioner_if.sv
// rtl/traffic_request_conditioner_if.sv - one request channel: raw input, green feedback, request and wait
interface traffic_request_conditioner_if #(
  parameter int WAIT_WIDTH = traffic_pkg::DEFAULT_WAIT_WIDTH
);
  logic                  raw;
  logic                  green;
  logic                  request;
  logic [WAIT_WIDTH-1:0] wait_count;

  modport master (output raw, output green, input request, input wait_count);
  modport slave  (input raw, input green, output request, output wait_count);
endinterface

// File: rtl/request_channel.sv
// rtl/request_channel.sv - synchronizer, debouncer, request FSM, pend flag and wait counter
module request_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WAIT_WIDTH      = DEFAULT_WAIT_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  traffic_request_conditioner_if.slave  ch
);

  localparam logic [7:0]            LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_MAX   = '1;
  localparam logic [WAIT_WIDTH-1:0] WAIT_ONE   = WAIT_WIDTH'(1);

  logic [1:0]            sync;
  logic                  level;
  logic [7:0]            count;
  logic                  rise;
  logic                  pend;
  logic                  request;
  logic [WAIT_WIDTH-1:0] wait_count;
  channel_state_t        state;

  // rise is a registered one-cycle pulse, so the FSM reacts one edge after the level flips
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      level <= 1'b0;
      count <= '0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], ch.raw};
      rise <= 1'b0;
      if (sync[1] == level) begin
        count <= '0;
      end else if (count == LAST_COUNT) begin
        level <= sync[1];
        count <= '0;
        rise  <= sync[1];
      end else begin
        count <= count + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      request    <= 1'b0;
      wait_count <= '0;
      pend       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state      <= ARMED;
            request    <= 1'b1;
            wait_count <= '0;
          end
        end
        ARMED: begin
          if (ch.green) begin
            state      <= SERVING;
            request    <= 1'b0;
            wait_count <= '0;
            pend       <= rise;
          end else if (wait_count != WAIT_MAX) begin
            wait_count <= wait_count + WAIT_ONE;
          end
        end
        SERVING: begin
          // a press landing on the same edge green drops still counts as pending
          if (!ch.green) begin
            pend <= 1'b0;
            if (pend || rise) begin
              state      <= ARMED;
              request    <= 1'b1;
              wait_count <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (rise) begin
            pend <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          request    <= 1'b0;
          wait_count <= '0;
          pend       <= 1'b0;
        end
      endcase
    end
  end

  assign ch.request    = request;
  assign ch.wait_count = wait_count;

  a_serving_quiet: assert property (@(posedge clock) disable iff (!reset_n)
    (state == SERVING) |-> !request);
  a_wait_no_wrap: assert property (@(posedge clock) disable iff (!reset_n)
    (request && $past(request)) |-> (wait_count >= $past(wait_count)));
  a_request_has_cause: assert property (@(posedge clock) disable iff (!reset_n)
    $rose(request) |-> $past(rise || pend));

endmodule

// File: rtl/traffic_request_conditioner.sv
// rtl/traffic_request_conditioner.sv - top: independent pedestrian and turn request channels
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WAIT_WIDTH      = DEFAULT_WAIT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pedestrian_button,
  input  logic                  turn_sensor,
  input  logic                  pedestrian_green,
  input  logic                  turn_green,
  output logic                  pedestrian_request,
  output logic                  turn_request,
  output logic [WAIT_WIDTH-1:0] pedestrian_wait,
  output logic [WAIT_WIDTH-1:0] turn_wait
);

  traffic_request_conditioner_if #(.WAIT_WIDTH(WAIT_WIDTH)) ped_ch ();
  traffic_request_conditioner_if #(.WAIT_WIDTH(WAIT_WIDTH)) turn_ch ();

  assign ped_ch.raw    = pedestrian_button;
  assign ped_ch.green  = pedestrian_green;
  assign turn_ch.raw   = turn_sensor;
  assign turn_ch.green = turn_green;

  assign pedestrian_request = ped_ch.request;
  assign pedestrian_wait    = ped_ch.wait_count;
  assign turn_request       = turn_ch.request;
  assign turn_wait          = turn_ch.wait_count;

  request_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WAIT_WIDTH     (WAIT_WIDTH)
  ) u_pedestrian (
    .clock  (clock),
    .reset_n(reset_n),
    .ch     (ped_ch)
  );

  request_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WAIT_WIDTH     (WAIT_WIDTH)
  ) u_turn (
    .clock  (clock),
    .reset_n(reset_n),
    .ch     (turn_ch)
  );

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// tb/tb_traffic_request_conditioner.sv - self-checking bench for traffic_request_conditioner
module tb_traffic_request_conditioner;

  localparam int DEB      = 4;
  localparam int WMAX     = 255;
  localparam int N_VEC    = 26;
  localparam int N_RANDOM = 3000;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   passed = 0;
  int   total  = 0;

  traffic_request_conditioner_if #(.WAIT_WIDTH(8)) ped ();
  traffic_request_conditioner_if #(.WAIT_WIDTH(8)) turn ();

  traffic_request_conditioner #(.DEBOUNCE_CYCLES(DEB), .WAIT_WIDTH(8)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pedestrian_button (ped.raw),
    .turn_sensor       (turn.raw),
    .pedestrian_green  (ped.green),
    .turn_green        (turn.green),
    .pedestrian_request(ped.request),
    .turn_request      (turn.request),
    .pedestrian_wait   (ped.wait_count),
    .turn_wait         (turn.wait_count)
  );

  always #5 clock = ~clock;

  // Reference model: sample history, stable-run length, and request bookkeeping per channel
  bit raw_log   [2][8];
  bit m_level   [2];
  int m_run     [2];
  bit m_rise    [2];
  bit m_req     [2];
  bit m_serving [2];
  bit m_pend    [2];
  int m_req_edge[2];
  int m_edge;
  int m_last;

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) raw_log[c][k] = 1'b0;
      m_level[c] = 0; m_run[c] = 0; m_rise[c] = 0;
      m_req[c] = 0; m_serving[c] = 0; m_pend[c] = 0; m_req_edge[c] = 0;
    end
    m_edge = 0;
    m_last = 0;
  endtask

  task automatic model_edge(input bit r0, input bit r1, input bit g0, input bit g1);
    bit raw [2];
    bit g   [2];
    bit sample;
    bit rise_now;
    raw[0] = r0; raw[1] = r1; g[0] = g0; g[1] = g1;
    for (int c = 0; c < 2; c++) begin
      raw_log[c][m_edge % 8] = raw[c];
      sample = (m_edge >= 2) ? raw_log[c][(m_edge - 2) % 8] : 1'b0;
      rise_now = 1'b0;
      if (sample != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_level[c] = sample;
          m_run[c]   = 0;
          rise_now   = sample;
        end
      end else begin
        m_run[c] = 0;
      end
      if (m_serving[c]) begin
        if (!g[c]) begin
          m_serving[c] = 0;
          if (m_pend[c] || m_rise[c]) begin
            m_req[c] = 1; m_req_edge[c] = m_edge;
          end
          m_pend[c] = 0;
        end else if (m_rise[c]) begin
          m_pend[c] = 1;
        end
      end else if (m_req[c]) begin
        if (g[c]) begin
          m_req[c] = 0; m_serving[c] = 1; m_pend[c] = m_rise[c];
        end
      end else if (m_rise[c]) begin
        m_req[c] = 1; m_req_edge[c] = m_edge;
      end
      m_rise[c] = rise_now;
    end
    m_last = m_edge;
    m_edge++;
  endtask

  function automatic int model_wait(input int c);
    int w;
    if (!m_req[c]) return 0;
    w = m_last - m_req_edge[c];
    return (w > WMAX) ? WMAX : w;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(ped.raw, turn.raw, ped.green, turn.green);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    ped.raw = 1'b0; ped.green = 1'b0; turn.raw = 1'b0; turn.green = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ped_req"}, ped.request, 0);
    check({name, " turn_req"}, turn.request, 0);
    check({name, " ped_wait"}, ped.wait_count, 0);
    check({name, " turn_wait"}, turn.wait_count, 0);
  endtask

  typedef struct {
    bit btn; bit sensor; bit pgreen; bit tgreen;
    bit exp_preq; bit exp_treq; int exp_pwait; int exp_twait;
  } vec_t;

  vec_t vecs[N_VEC];

  initial begin
    // press, service with re-press during green (pend), turn channel pressed meanwhile
    for (int i = 0; i < N_VEC; i++) begin
      vecs[i].btn       = (i <= 8) || (i >= 15);
      vecs[i].pgreen    = (i >= 8) && (i <= 22);
      vecs[i].sensor    = (i >= 10);
      vecs[i].tgreen    = 1'b0;
      vecs[i].exp_preq  = (i == 6) || (i == 7) || (i >= 23);
      vecs[i].exp_pwait = (i == 7) ? 1 : ((i >= 23) ? i - 23 : 0);
      vecs[i].exp_treq  = (i >= 16);
      vecs[i].exp_twait = (i >= 16) ? i - 16 : 0;
    end

    ped.raw = 1'b0; ped.green = 1'b0; turn.raw = 1'b0; turn.green = 1'b0;
    model_clear();
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    apply_reset();

    for (int i = 0; i < N_VEC; i++) begin
      ped.raw = vecs[i].btn; ped.green = vecs[i].pgreen;
      turn.raw = vecs[i].sensor; turn.green = vecs[i].tgreen;
      step();
      check($sformatf("table[%0d] ped_req", i), ped.request, vecs[i].exp_preq);
      check($sformatf("table[%0d] ped_wait", i), ped.wait_count, vecs[i].exp_pwait);
      check($sformatf("table[%0d] turn_req", i), turn.request, vecs[i].exp_treq);
      check($sformatf("table[%0d] turn_wait", i), turn.wait_count, vecs[i].exp_twait);
    end

    // bounce: three-high/one-low pulses never qualify, the final hold does
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      ped.raw = (i >= 12) || ((i % 4) != 3);
      step();
      check($sformatf("bounce[%0d] ped_req", i), ped.request, (i >= 18) ? 1 : 0);
    end

    // saturation
    apply_reset();
    ped.raw = 1'b1;
    for (int i = 0; i < 320; i++) begin
      step();
      if (i == 6)   check("sat first req", ped.request, 1);
      if (i == 260) check("sat wait 254", ped.wait_count, 254);
      if (i == 261) check("sat wait 255", ped.wait_count, 255);
      if (i == 319) begin
        check("sat wait held", ped.wait_count, 255);
        check("sat req held", ped.request, 1);
      end
    end

    // simultaneous rise; turn_green affects only turn
    apply_reset();
    ped.raw = 1'b1; turn.raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      turn.green = (i >= 8);
      step();
      if (i == 5) begin
        check("simul ped before", ped.request, 0);
        check("simul turn before", turn.request, 0);
      end
      if (i == 6) begin
        check("simul ped rise", ped.request, 1);
        check("simul turn rise", turn.request, 1);
      end
      if (i == 9) begin
        check("simul turn served", turn.request, 0);
        check("simul ped kept", ped.request, 1);
        check("simul ped wait", ped.wait_count, 3);
      end
    end

    // asynchronous reset mid-operation, then release with the button held
    apply_reset();
    ped.raw = 1'b1;
    for (int i = 0; i <= 46; i++) step();
    check("midreset wait 40", ped.wait_count, 40);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset async");
    model_clear();
    @(posedge clock);
    #1 check("midreset held low", ped.request, 0);
    reset_n = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      if (i == 5) check("rerelease before", ped.request, 0);
      if (i == 6) check("rerelease req", ped.request, 1);
    end

    // randomized run against the reference model
    apply_reset();
    for (int i = 0; i < N_RANDOM; i++) begin
      if ($urandom_range(5) == 0) ped.raw = ~ped.raw;
      if ($urandom_range(5) == 0) turn.raw = ~turn.raw;
      if ($urandom_range(9) == 0) ped.green = ~ped.green;
      if ($urandom_range(9) == 0) turn.green = ~turn.green;
      step();
      check($sformatf("rand[%0d] ped_req", i), ped.request, m_req[0]);
      check($sformatf("rand[%0d] ped_wait", i), ped.wait_count, model_wait(0));
      check($sformatf("rand[%0d] turn_req", i), turn.request, m_req[1]);
      check($sformatf("rand[%0d] turn_wait", i), turn.wait_count, model_wait(1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
